// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, default latencies and FSM state type for the mult/div unit.
package md_pkg;
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam int MULT_LAT_D = 5;
    localparam int DIV_LAT_D  = 10;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owning the HI/LO registers.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_D,
    parameter int DIV_LAT  = DIV_LAT_D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_wr;
    logic          sgn, is_md, is_div;
    logic [63:0]   prod;
    logic [31:0]   abs_a, abs_b, uq, ur, dq, dr;

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    always_comb begin
        is_md  = ~op[2];
        is_div = op[1];
        sgn    = ~op[0];
        prod   = sgn ? {{32{A[31]}}, A} * {{32{B[31]}}, B} : {32'b0, A} * {32'b0, B};
        abs_a  = sgn && A[31] ? -A : A;
        abs_b  = sgn && B[31] ? -B : B;
        uq     = abs_b == '0 ? '0 : abs_a / abs_b;
        ur     = abs_b == '0 ? '0 : abs_a % abs_b;
        dq     = sgn && (A[31] ^ B[31]) ? -uq : uq;
        dr     = sgn && A[31] ? -ur : ur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (state == IDLE) begin
            if (start && is_md) begin
                state              <= RUN;
                busy               <= 1'b1;
                count              <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                {pend_hi, pend_lo} <= is_div ? {dr, dq} : prod;
                pend_wr            <= !(is_div && B == '0);
            end else if (start && op == MD_MTHI) begin
                HI <= A;
            end else if (start && op == MD_MTLO) begin
                LO <= A;
            end
        end else if (count == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
            if (pend_wr) {HI, LO} <= {pend_hi, pend_lo};
        end else begin
            count <= count - CW'(1);
        end
    end
endmodule
